// File: rtl/led_pattern_engine_if.sv
// Control/status bundle between the button/switch synchronisers and the LED sequencer.
interface led_pattern_engine_if #(
  parameter int WIDTH = 8
);
  logic             b;
  logic             p;
  logic [1:0]       mode;
  logic             hold;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (output b, p, mode, hold, input out, busy, done);
  modport slave  (input b, p, mode, hold, output out, busy, done);
endinterface

// File: rtl/led_pattern_engine.sv
// Prescaled LED sequencer: dot/bar patterns, bounce/chase motion, pause,
// and a bounded (or endless) all-on/all-off flash at the end of a run.
module led_pattern_engine #(
  parameter int WIDTH   = 8,
  parameter int DIV     = 1,
  parameter int FLASH_N = 3
) (
  input  logic                 Clk,
  input  logic                 r_n,
  led_pattern_engine_if.slave  io
);

  localparam int PW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (FLASH_N > 0) ? $clog2(FLASH_N + 1) : 1;

  localparam logic [PW-1:0] POS_MAX   = PW'(WIDTH - 1);
  localparam logic [PW-1:0] POS_ONE   = PW'(1);
  localparam logic [DW-1:0] PRE_MAX   = DW'(DIV - 1);
  localparam logic [DW-1:0] PRE_ONE   = DW'(1);
  localparam logic [FW-1:0] FLASH_LIM = FW'(FLASH_N);
  localparam logic [FW-1:0] FLASH_ONE = FW'(1);

  typedef enum logic [1:0] {IDLE, RUN, FLASH_ON, FLASH_OFF} state_t;
  typedef enum logic {UP, DOWN} dir_t;

  state_t           state;
  dir_t             dir;
  logic [PW-1:0]    pos;
  logic [DW-1:0]    pre;
  logic [FW-1:0]    flash_cnt;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] out_q;
  logic             busy_q;
  logic             done_q;
  logic             tick;

  assign tick    = (pre == PRE_MAX);
  assign io.out  = out_q;
  assign io.busy = busy_q;
  assign io.done = done_q;

  // bar lights bits 0..ps; the shift past the top bit wraps to all-ones after -1.
  function automatic logic [WIDTH-1:0] pattern(input logic bar, input logic [PW-1:0] ps);
    logic [WIDTH-1:0] one;
    logic [WIDTH-1:0] one_hot;
    one     = {{(WIDTH-1){1'b0}}, 1'b1};
    one_hot = one << ps;
    return bar ? ((one_hot << 1) - one) : one_hot;
  endfunction

  // NOTE: every state register, including out, has an async reset so the
  // LEDs go dark the instant r_n falls, not at the next edge.
  always_ff @(posedge Clk or negedge r_n) begin
    if (!r_n) begin
      state     <= IDLE;
      dir       <= UP;
      pos       <= '0;
      pre       <= '0;
      flash_cnt <= '0;
      mode_q    <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; all reads below see pre-edge values.
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (io.b) begin
          state     <= RUN;
          dir       <= UP;
          pos       <= '0;
          pre       <= '0;
          flash_cnt <= '0;
          mode_q    <= io.mode;
          busy_q    <= 1'b1;
          out_q     <= pattern(io.mode[1], '0);
        end
      end else if (!io.hold) begin
        pre <= tick ? '0 : pre + PRE_ONE;
        if (tick) begin
          case (state)
            RUN: begin
              if (mode_q[0]) begin
                if (pos == POS_MAX) begin
                  if (io.p) begin
                    pos   <= '0;
                    out_q <= pattern(mode_q[1], '0);
                  end else begin
                    state <= FLASH_ON;
                    out_q <= '1;
                  end
                end else begin
                  pos   <= pos + POS_ONE;
                  out_q <= pattern(mode_q[1], pos + POS_ONE);
                end
              end else if (dir == UP) begin
                if (pos == POS_MAX) begin
                  dir   <= DOWN;
                  pos   <= pos - POS_ONE;
                  out_q <= pattern(mode_q[1], pos - POS_ONE);
                end else begin
                  pos   <= pos + POS_ONE;
                  out_q <= pattern(mode_q[1], pos + POS_ONE);
                end
              end else begin
                if (pos == '0) begin
                  if (io.p) begin
                    dir   <= UP;
                    pos   <= POS_ONE;
                    out_q <= pattern(mode_q[1], POS_ONE);
                  end else begin
                    state <= FLASH_ON;
                    out_q <= '1;
                  end
                end else begin
                  pos   <= pos - POS_ONE;
                  out_q <= pattern(mode_q[1], pos - POS_ONE);
                end
              end
            end
            FLASH_ON: begin
              state <= FLASH_OFF;
              out_q <= '0;
            end
            FLASH_OFF: begin
              flash_cnt <= flash_cnt + FLASH_ONE;
              if (FLASH_N != 0 && (flash_cnt + FLASH_ONE) == FLASH_LIM) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                out_q  <= '0;
              end else begin
                state <= FLASH_ON;
                out_q <= '1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench: three engine instances (bounded flash DIV=1, DIV=4, endless flash).
module tb_led_pattern_engine;

  logic Clk = 1'b0;
  logic r_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 Clk = ~Clk;

  led_pattern_engine_if #(.WIDTH(8)) if_a ();
  led_pattern_engine_if #(.WIDTH(8)) if_b ();
  led_pattern_engine_if #(.WIDTH(8)) if_c ();

  led_pattern_engine #(.WIDTH(8), .DIV(1), .FLASH_N(3)) u_a (.Clk(Clk), .r_n(r_n), .io(if_a));
  led_pattern_engine #(.WIDTH(8), .DIV(4), .FLASH_N(3)) u_b (.Clk(Clk), .r_n(r_n), .io(if_b));
  led_pattern_engine #(.WIDTH(8), .DIV(1), .FLASH_N(0)) u_c (.Clk(Clk), .r_n(r_n), .io(if_c));

  logic [7:0] bounce_seq [15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] bar_seq [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset();
    #2 r_n = 1'b0;
    #2 r_n = 1'b1;
    step(1);
  endtask

  initial begin
    {if_a.b, if_a.p, if_a.hold, if_a.mode} = '0;
    {if_b.b, if_b.p, if_b.hold, if_b.mode} = '0;
    {if_c.b, if_c.p, if_c.hold, if_c.mode} = '0;

    // Reset and idle
    #12 r_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_out",  {24'h0, if_a.out}, 32'h00);
      check("idle_busy", {31'h0, if_a.busy}, 32'h0);
      check("idle_done", {31'h0, if_a.done}, 32'h0);
    end
    check("idle_busy_b", {31'h0, if_b.busy}, 32'h0);
    check("idle_out_c",  {24'h0, if_c.out}, 32'h00);

    // Bounce dot, single run, three flash pairs then done
    if_a.mode = 2'b00; if_a.p = 1'b0; if_a.b = 1'b1;
    step(1);
    if_a.b = 1'b0;
    check("bnc_start_busy", {31'h0, if_a.busy}, 32'h1);
    check("bnc_run0", {24'h0, if_a.out}, {24'h0, bounce_seq[0]});
    for (int i = 1; i < 15; i++) begin
      step(1);
      check("bnc_run", {24'h0, if_a.out}, {24'h0, bounce_seq[i]});
    end
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("bnc_flash_on",  {24'h0, if_a.out}, 32'hFF);
      check("bnc_flash_done", {31'h0, if_a.done}, 32'h0);
      step(1);
      check("bnc_flash_off", {24'h0, if_a.out}, 32'h00);
      check("bnc_flash_busy", {31'h0, if_a.busy}, 32'h1);
    end
    step(1);
    check("bnc_end_out",  {24'h0, if_a.out}, 32'h00);
    check("bnc_end_done", {31'h0, if_a.done}, 32'h1);
    check("bnc_end_busy", {31'h0, if_a.busy}, 32'h0);
    step(1);
    check("bnc_done_pulse", {31'h0, if_a.done}, 32'h0);
    check("bnc_idle_out",   {24'h0, if_a.out}, 32'h00);

    // Bounce repeat, hold, start-while-busy, mode change ignored
    do_reset();
    if_a.mode = 2'b00; if_a.p = 1'b1; if_a.b = 1'b1;
    step(1);
    if_a.b = 1'b0;
    check("rep_run0", {24'h0, if_a.out}, {24'h0, bounce_seq[0]});
    for (int i = 1; i < 15; i++) begin
      step(1);
      check("rep_run", {24'h0, if_a.out}, {24'h0, bounce_seq[i]});
    end
    step(1); check("rep_turn", {24'h0, if_a.out}, 32'h02);
    step(1); check("rep_04",   {24'h0, if_a.out}, 32'h04);
    step(1); check("rep_08",   {24'h0, if_a.out}, 32'h08);
    if_a.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("hold_out", {24'h0, if_a.out}, 32'h08);
    end
    if_a.hold = 1'b0;
    step(1); check("hold_release", {24'h0, if_a.out}, 32'h10);
    if_a.b = 1'b1;
    step(1); check("b_busy_ignored", {24'h0, if_a.out}, 32'h20);
    if_a.b = 1'b0; if_a.mode = 2'b11;
    step(1); check("mode_ignored", {24'h0, if_a.out}, 32'h40);
    check("rep_busy", {31'h0, if_a.busy}, 32'h1);
    step(1); check("rep_80", {24'h0, if_a.out}, 32'h80);
    if_a.mode = 2'b00;

    // Chase bar, DIV=4, repeat then drop p during FF
    do_reset();
    check("rst_a_out", {24'h0, if_a.out}, 32'h00);
    if_b.mode = 2'b11; if_b.p = 1'b1; if_b.b = 1'b1;
    step(1);
    if_b.b = 1'b0;
    check("chs_first", {24'h0, if_b.out}, 32'h01);
    for (int r = 1; r < 4; r++) begin
      step(1);
      check("chs_hold01", {24'h0, if_b.out}, 32'h01);
    end
    for (int v = 1; v < 8; v++)
      for (int r = 0; r < 4; r++) begin
        step(1);
        check("chs_pass1", {24'h0, if_b.out}, {24'h0, bar_seq[v]});
      end
    for (int v = 0; v < 7; v++)
      for (int r = 0; r < 4; r++) begin
        step(1);
        check("chs_pass2", {24'h0, if_b.out}, {24'h0, bar_seq[v]});
      end
    step(1);
    check("chs_ff", {24'h0, if_b.out}, 32'hFF);
    if_b.p = 1'b0;
    for (int r = 0; r < 7; r++) begin
      step(1);
      check("chs_ff_flash_on", {24'h0, if_b.out}, 32'hFF);
    end
    for (int r = 0; r < 4; r++) begin
      step(1);
      check("chs_flash_off", {24'h0, if_b.out}, 32'h00);
      check("chs_flash_busy", {31'h0, if_b.busy}, 32'h1);
    end
    step(1);
    check("chs_flash_on2", {24'h0, if_b.out}, 32'hFF);

    // Endless flash, then asynchronous reset between edges
    do_reset();
    if_c.mode = 2'b00; if_c.p = 1'b0; if_c.b = 1'b1;
    step(1);
    if_c.b = 1'b0;
    check("inf_run0", {24'h0, if_c.out}, {24'h0, bounce_seq[0]});
    for (int i = 1; i < 15; i++) begin
      step(1);
      check("inf_run", {24'h0, if_c.out}, {24'h0, bounce_seq[i]});
    end
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("inf_flash", {24'h0, if_c.out}, (i % 2 == 0) ? 32'hFF : 32'h00);
      check("inf_no_done", {31'h0, if_c.done}, 32'h0);
      check("inf_busy", {31'h0, if_c.busy}, 32'h1);
    end
    step(1);
    check("inf_pre_rst", {24'h0, if_c.out}, 32'hFF);
    #2 r_n = 1'b0;
    #1;
    check("async_rst_out",  {24'h0, if_c.out}, 32'h00);
    check("async_rst_busy", {31'h0, if_c.busy}, 32'h0);
    #2 r_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("post_rst_out",  {24'h0, if_c.out}, 32'h00);
      check("post_rst_busy", {31'h0, if_c.busy}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
